// File: rtl/xgmii_rx_frame_monitor.sv
// Frame checker on the lane-0-aligned 64-bit XGMII RX stream: delimits frames,
// measures length, classifies errors, tracks link-fault ordered sets.
module xgmii_rx_frame_monitor #(
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int FAULT_CLR = 128
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic        clear_cnt,
    output logic        frame_done,
    output logic [15:0] frame_len,
    output logic [3:0]  frame_status,
    output logic [31:0] good_cnt,
    output logic [31:0] bad_cnt,
    output logic        local_fault,
    output logic        remote_fault
);
    localparam int FCW = $clog2(FAULT_CLR + 1);
    localparam logic [FCW-1:0] FCLR = FCW'(FAULT_CLR);

    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

    function automatic logic [15:0] len_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [31:0] cnt_inc(input logic [31:0] a);
        return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
    endfunction

    state_t         state_q, state_d;
    logic [15:0]    len_q, len_d;
    logic           ctrl_q, ctrl_d, pre_q, pre_d;
    logic           done_q;
    logic [15:0]    flen_q, flen_d;
    logic [3:0]     fstat_q, fstat_d;
    logic [31:0]    good_q, good_d, bad_q, bad_d;
    logic           lf_q, lf_d, rf_q, rf_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    logic [2:0]  k_lane;
    logic [7:0]  k_byte;
    logic        start_w, pre_bad, close, close_ctrl;
    logic [15:0] close_len;
    logic        fault_seq, lf_word, rf_word;

    always_comb begin
        k_lane = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (xgmii_rxc[i]) k_lane = 3'(i);
        end
        k_byte  = xgmii_rxd[{k_lane, 3'b000} +: 8];
        start_w = xgmii_rxc[0] && (xgmii_rxd[7:0] == 8'hFB);
        pre_bad = (xgmii_rxc[7:1] != 7'd0) || (xgmii_rxd[63:8] != 56'hD5_5555_5555_5555);

        state_d    = state_q;
        len_d      = len_q;
        ctrl_d     = ctrl_q;
        pre_d      = pre_q;
        close      = 1'b0;
        close_ctrl = ctrl_q;
        close_len  = len_q;

        if (state_q == IDLE) begin
            if (start_w) begin
                state_d = FRAME;
                len_d   = 16'd0;
                ctrl_d  = 1'b0;
                pre_d   = pre_bad;
            end
        end else if (xgmii_rxc == 8'd0) begin
            len_d = len_add(len_q, 4'd8);
        end else if (k_byte == 8'hFD) begin
            close     = 1'b1;
            close_len = len_add(len_q, {1'b0, k_lane});
            state_d   = IDLE;
        end else if (k_lane == 3'd0 && k_byte == 8'hFB) begin
            // Back-to-back start: close the old frame as errored, reopen on this word.
            close      = 1'b1;
            close_ctrl = 1'b1;
            len_d      = 16'd0;
            ctrl_d     = 1'b0;
            pre_d      = pre_bad;
        end else if (k_byte == 8'hFE) begin
            ctrl_d = 1'b1;
            len_d  = len_add(len_q, 4'd8);
        end else begin
            close      = 1'b1;
            close_ctrl = 1'b1;
            close_len  = len_add(len_q, {1'b0, k_lane});
            state_d    = IDLE;
        end

        flen_d  = flen_q;
        fstat_d = fstat_q;
        if (close) begin
            flen_d  = close_len;
            fstat_d = {close_len > 16'(MAX_LEN), close_len < 16'(MIN_LEN), close_ctrl, pre_q};
        end

        good_d = good_q;
        bad_d  = bad_q;
        if (clear_cnt) begin
            good_d = 32'd0;
            bad_d  = 32'd0;
        end else if (close) begin
            if (fstat_d == 4'd0) good_d = cnt_inc(good_q);
            else                 bad_d  = cnt_inc(bad_q);
        end

        fault_seq = (xgmii_rxc[3:0] == 4'h1) && (xgmii_rxd[7:0] == 8'h9C) &&
                    (xgmii_rxd[23:8] == 16'd0);
        lf_word   = fault_seq && (xgmii_rxd[31:24] == 8'h01);
        rf_word   = fault_seq && (xgmii_rxd[31:24] == 8'h02);
        lf_d      = lf_q;
        rf_d      = rf_q;
        fcnt_d    = fcnt_q;
        if (lf_word || rf_word) begin
            lf_d   = lf_word;
            rf_d   = rf_word;
            fcnt_d = '0;
        end else begin
            if (fcnt_q != FCLR) fcnt_d = fcnt_q + 1'b1;
            if (fcnt_d == FCLR) begin
                lf_d = 1'b0;
                rf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            ctrl_q  <= 1'b0;
            pre_q   <= 1'b0;
            done_q  <= 1'b0;
            flen_q  <= '0;
            fstat_q <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            lf_q    <= 1'b0;
            rf_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ctrl_q  <= ctrl_d;
            pre_q   <= pre_d;
            done_q  <= close;
            flen_q  <= flen_d;
            fstat_q <= fstat_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            lf_q    <= lf_d;
            rf_q    <= rf_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign frame_done   = done_q;
    assign frame_len    = flen_q;
    assign frame_status = fstat_q;
    assign good_cnt     = good_q;
    assign bad_cnt      = bad_q;
    assign local_fault  = lf_q;
    assign remote_fault = rf_q;
endmodule

// File: tb/tb_xgmii_rx_frame_monitor.sv
// Scoreboard bench: stimulus feeds a frame-level reference model that queues
// expected closes and fault flags; a negedge monitor compares DUT outputs.
module tb_xgmii_rx_frame_monitor;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int FAULT_CLR = 128;
    localparam logic [63:0] START_D = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] IDLE_D  = 64'h0707_0707_0707_0707;

    logic        clk156 = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [63:0] xgmii_rxd = IDLE_D;
    logic [7:0]  xgmii_rxc = 8'hFF;
    logic        clear_cnt = 1'b0;
    logic        frame_done;
    logic [15:0] frame_len;
    logic [3:0]  frame_status;
    logic [31:0] good_cnt, bad_cnt;
    logic        local_fault, remote_fault;

    xgmii_rx_frame_monitor #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .FAULT_CLR(FAULT_CLR)) dut (
        .clk156(clk156), .sys_rst_n(sys_rst_n), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
        .clear_cnt(clear_cnt), .frame_done(frame_done), .frame_len(frame_len),
        .frame_status(frame_status), .good_cnt(good_cnt), .bad_cnt(bad_cnt),
        .local_fault(local_fault), .remote_fault(remote_fault));

    always #5 clk156 = ~clk156;

    int cyc = 0;
    always @(posedge clk156) cyc <= cyc + 1;

    typedef struct { int due; logic [15:0] len; logic [3:0] st; logic [31:0] g; logic [31:0] b; } fexp_t;
    typedef struct { int due; bit lf; bit rf; } flt_t;
    fexp_t sq[$];
    flt_t  fq[$];

    int total = 0;
    int nbad  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state: frame-level view with unbounded length.
    bit     m_in;
    int     m_len;
    bit     m_ctrl, m_pre;
    longint m_good, m_bad;
    bit     m_lf, m_rf;
    int     m_quiet;

    task automatic model_reset();
        m_in = 0; m_len = 0; m_ctrl = 0; m_pre = 0;
        m_good = 0; m_bad = 0; m_lf = 0; m_rf = 0; m_quiet = 0;
    endtask

    task automatic model(input logic [7:0] c, input logic [63:0] d, input bit clr);
        int k;
        logic [7:0] b;
        bit close, cctrl, cpre, is_start, pbad, fl, fr;
        int clen;
        fexp_t e;
        flt_t f;
        k = -1;
        for (int i = 0; i < 8; i++) if (c[i] && k < 0) k = i;
        is_start = c[0] && d[7:0] == 8'hFB;
        pbad = !(c == 8'h01 && d == START_D);
        close = 0; cctrl = 0; cpre = m_pre; clen = 0;
        if (!m_in) begin
            if (is_start) begin m_in = 1; m_len = 0; m_ctrl = 0; m_pre = pbad; end
        end else if (k < 0) begin
            m_len += 8;
        end else begin
            b = d[8*k +: 8];
            if (b == 8'hFD) begin
                close = 1; clen = m_len + k; cctrl = m_ctrl; m_in = 0;
            end else if (k == 0 && b == 8'hFB) begin
                close = 1; clen = m_len; cctrl = 1;
                m_len = 0; m_ctrl = 0; m_pre = pbad;
            end else if (b == 8'hFE) begin
                m_ctrl = 1; m_len += 8;
            end else begin
                close = 1; clen = m_len + k; cctrl = 1; m_in = 0;
            end
        end
        if (close) begin
            if (clen > 65535) clen = 65535;
            e.st = {clen > MAX_LEN, clen < MIN_LEN, cctrl, cpre};
            if (e.st == 0) m_good = (m_good + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_good + 1;
            else           m_bad  = (m_bad + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bad + 1;
        end
        if (clr) begin m_good = 0; m_bad = 0; end
        if (close) begin
            e.due = cyc + 1; e.len = 16'(clen);
            e.g = 32'(m_good); e.b = 32'(m_bad);
            sq.push_back(e);
        end
        fl = c[3:0] == 4'h1 && d[23:0] == 24'h00009C && d[31:24] == 8'h01;
        fr = c[3:0] == 4'h1 && d[23:0] == 24'h00009C && d[31:24] == 8'h02;
        if (fl || fr) begin m_lf = fl; m_rf = fr; m_quiet = 0; end
        else begin
            m_quiet++;
            if (m_quiet >= FAULT_CLR) begin m_lf = 0; m_rf = 0; end
        end
        f.due = cyc + 1; f.lf = m_lf; f.rf = m_rf;
        fq.push_back(f);
    endtask

    task automatic send(input logic [7:0] c, input logic [63:0] d, input bit clr = 0);
        @(posedge clk156); #1;
        xgmii_rxc = c; xgmii_rxd = d; clear_cnt = clr;
        model(c, d, clr);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic data(input int n);
        for (int i = 0; i < n; i++) send(8'h00, rnd64());
    endtask

    task automatic term(input int k, input logic [7:0] ch, input bit clr = 0);
        logic [63:0] d;
        logic [7:0]  c;
        d = rnd64();
        c = 8'(8'hFF << k);
        for (int i = 0; i < 8; i++) if (i > k) d[8*i +: 8] = 8'h07;
        d[8*k +: 8] = ch;
        send(c, d, clr);
    endtask

    task automatic fault_word(input logic [7:0] code);
        send(8'h01, {32'h0, code, 16'h0000, 8'h9C});
    endtask

    task automatic check_zero();
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_frame_status", frame_status, 0);
        chk("rst_good_cnt", good_cnt, 0);
        chk("rst_bad_cnt", bad_cnt, 0);
        chk("rst_local_fault", local_fault, 0);
        chk("rst_remote_fault", remote_fault, 0);
    endtask

    task automatic do_reset();
        @(negedge clk156); #1;
        sys_rst_n = 0;
        #1;
        check_zero();
        model_reset();
        sq.delete(); fq.delete();
        xgmii_rxc = 8'hFF; xgmii_rxd = IDLE_D; clear_cnt = 0;
        repeat (2) @(posedge clk156);
        @(negedge clk156);
        sys_rst_n = 1;
    endtask

    task automatic rand_frame();
        logic [63:0] d;
        int n, sel, j;
        d = START_D;
        if ($urandom_range(0, 7) == 0) begin
            j = $urandom_range(1, 7);
            d[8*j +: 8] = d[8*j +: 8] ^ 8'($urandom_range(1, 255));
        end
        send(8'h01, d);
        n = $urandom_range(0, 200);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                j = $urandom_range(0, 7);
                d = rnd64();
                d[8*j +: 8] = 8'hFE;
                send(8'(8'h01 << j), d);
            end else send(8'h00, rnd64());
        end
        sel = $urandom_range(0, 7);
        if (sel == 0) term($urandom_range(0, 7), 8'h07);
        else if (sel == 1) begin
            send(8'h01, START_D);
            data($urandom_range(0, 20));
            term($urandom_range(0, 7), 8'hFD);
        end else term($urandom_range(0, 7), 8'hFD, $urandom_range(0, 15) == 0);
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 5);
            if (sel == 0) send(8'h00, rnd64());
            else if (sel == 1) fault_word(8'($urandom_range(1, 2)));
            else send(8'hFF, IDLE_D);
        end
    endtask

    // Monitor: fault flags every due cycle, frame results on each pulse.
    always @(negedge clk156) begin
        if (sys_rst_n) begin
            while (fq.size() > 0 && fq[0].due <= cyc) begin
                chk("local_fault", local_fault, fq[0].lf);
                chk("remote_fault", remote_fault, fq[0].rf);
                void'(fq.pop_front());
            end
            if (sq.size() > 0 && sq[0].due <= cyc) begin
                chk("frame_done_at_due", frame_done, 1);
                if (frame_done) begin
                    chk("frame_len", frame_len, sq[0].len);
                    chk("frame_status", frame_status, sq[0].st);
                    chk("good_cnt", good_cnt, sq[0].g);
                    chk("bad_cnt", bad_cnt, sq[0].b);
                end
                void'(sq.pop_front());
            end else if (frame_done) begin
                chk("frame_done_unexpected", frame_done, 0);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk156);
        #1;
        check_zero();
        @(negedge clk156);
        sys_rst_n = 1;
        send(8'hFF, IDLE_D);

        // good 72-byte frame
        send(8'h01, START_D); data(9); send(8'hFF, 64'h0707_0707_0707_07FD);
        // runt: 59 bytes
        send(8'h01, START_D); data(7); term(3, 8'hFD);
        // FE error mid-frame: 80 bytes, ctrl_err
        send(8'h01, START_D); data(4); send(8'h08, 64'h0000_0000_FE00_0000); data(5); term(0, 8'hFD);
        // idle inside a frame: 24 bytes, ctrl_err + runt
        send(8'h01, START_D); data(3); send(8'hFF, IDLE_D);
        // restart inside a frame, then a normal frame from that start
        send(8'h01, START_D); data(10); send(8'h01, START_D); data(8); term(4, 8'hFD);
        // bad preamble
        send(8'h01, 64'hD555_5555_5554_55FB); data(10); term(0, 8'hFD);
        send(8'hFF, IDLE_D);

        // fault sequencing
        repeat (4) fault_word(8'h01);
        repeat (FAULT_CLR) send(8'hFF, IDLE_D);
        fault_word(8'h01); send(8'hFF, IDLE_D); fault_word(8'h02);
        repeat (5) send(8'hFF, IDLE_D);

        // reset mid-frame, then a good frame
        send(8'h01, START_D); data(5);
        do_reset();
        send(8'h01, START_D); data(8); term(0, 8'hFD);
        // clear_cnt coincident with a close
        send(8'h01, START_D); data(8); term(2, 8'hFD, 1);
        // giant and length saturation
        send(8'h01, START_D); data(190); term(0, 8'hFD);
        send(8'h01, START_D); data(8200); term(7, 8'hFD);
        send(8'hFF, IDLE_D);

        for (int f = 0; f < 60; f++) rand_frame();
        repeat (6) send(8'hFF, IDLE_D);
        repeat (3) @(posedge clk156);
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule

// File: doc/xgmii_rx_frame_monitor.md
Name: xgmii_rx_frame_monitor

Overview:
- Receive-side frame checker on the 64-bit XGMII RX path, clocked by clk156.
- Sits directly downstream of xgmiisync and consumes its lane-0-aligned xgmii_rxd/xgmii_rxc output.
- Delimits each frame, measures its length, classifies errors and detects link-fault sequence ordered sets.
- Exposes per-frame results plus saturating good/bad counters for LEDs and debug.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS)
MAX_LEN, 1518, maximum legal frame length in bytes
FAULT_CLR, 128, consecutive non-fault words required to clear a fault flag

Ports:
clk156  in  1  XGMII 156.25 MHz clock
sys_rst_n  in  1  asynchronous active-low reset
xgmii_rxd  in  64  RX data; lane k = bits [8k+7:8k]; lane 0 is first on the wire
xgmii_rxc  in  8  RX control; bit k flags lane k as a control character
clear_cnt  in  1  synchronous clear of good_cnt/bad_cnt
frame_done  out  1  one-cycle pulse; a frame has closed
frame_len  out  16  byte length of the closed frame, valid while frame_done=1
frame_status  out  4  {giant, runt, ctrl_err, preamble_err}, valid while frame_done=1
good_cnt  out  32  count of frames closed with frame_status=0
bad_cnt  out  32  count of frames closed with frame_status!=0
local_fault  out  1  local fault sequence present
remote_fault  out  1  remote fault sequence present

Behaviour:
- Reset: every output and every internal register is 0; the FSM enters IDLE. Reset takes effect immediately, including mid-frame. No frame_done pulse is issued for an interrupted frame.
- Start word: rxc=8'h01 and rxd=64'hD5_55_55_55_55_55_55_FB. Start is recognised only in lane 0.
- A word with rxc[0]=1, rxd[7:0]=FB but a wrong preamble/SFD still starts a frame, with preamble_err set.
- FSM IDLE: on a start word, go to FRAME with len=0 and flags cleared. All other words are ignored for framing.
- FSM FRAME, rxc=0: len += 8. len saturates at 16'hFFFF.
- FSM FRAME, rxc!=0: let k be the lowest lane with its rxc bit set.
  - Byte k = FD: len += k, close the frame, return to IDLE.
  - k=0 and byte = FB: close the current frame with ctrl_err set. The same word starts a new frame; stay in FRAME.
  - Byte k = FE: set ctrl_err, len += 8, stay in FRAME.
  - Any other control character (e.g. 07 idle): set ctrl_err, len += k, close the frame, return to IDLE.
  - Lanes above k are not checked.
- Close: runt = len < MIN_LEN; giant = len > MAX_LEN.
- Latency: the word that closes a frame is sampled at edge N. frame_done=1 with frame_len/frame_status valid during cycle N+1. The counters reflect that frame from cycle N+1.
- frame_len/frame_status hold their value until the next close.
- Counters saturate at 32'hFFFFFFFF.
- clear_cnt has priority: if it coincides with a close, the counters become 0 and that frame is not counted. frame_done still pulses.
- Fault sequence: rxc[3:0]=4'h1, lane0=9C, lanes1-2=00.
  - Lane3=01 sets local_fault.
  - Lane3=02 sets remote_fault.
  - The other fault flag clears on the same cycle.
  - Each flag clears after FAULT_CLR consecutive words that contain no fault sequence; the word counter saturates.
  - Fault words in IDLE do not affect framing.

Test Plan:
- Idle, then start word, 9 data words, then rxc=FF / rxd=07..07_FD -> frame_done one cycle after the terminate word, frame_len=72, frame_status=0, good_cnt=1.
- Start, 7 data words, terminate with FD in lane 3 -> frame_len=59, frame_status=4'b0100 (runt), bad_cnt=1.
- Start, 4 data words, word with rxc=8'h08 and lane3=FE, 5 data words, FD in lane 0 -> frame_len=80, frame_status=4'b0010, bad_cnt increments.
- Start, 3 data words, idle word (rxc=FF, all 07) -> frame_done with frame_len=24 and ctrl_err+runt. A second start inside a frame -> the first frame closes with ctrl_err, then the new frame measures normally.
- Four local-fault words (lane3=01) -> local_fault=1 from the edge after the first; then 127 idle words -> still 1; the 128th -> 0. A remote-fault word while local_fault=1 -> remote_fault=1, local_fault=0.
- Assert sys_rst_n low mid-frame -> all outputs 0 immediately with no pulse; the next good frame reports correctly. clear_cnt coincident with a close -> counters 0, frame_done still pulses. Preloaded counter at all-ones plus another frame -> stays all-ones.
